// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bundle: decode-side instruction fields in, registered EX slot,
// hazard stall and bubble counter out.
interface id_ex_stage_if;
    logic        ID_Valid;
    logic        RegDst;
    logic        ALUSrc;
    logic        MemtoReg;
    logic        RegWrite;
    logic        MemRead;
    logic        MemWrite;
    logic        Branch;
    logic        Jump;
    logic        SignZero;
    logic [1:0]  ALUOp;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic [15:0] Imm16;
    logic [4:0]  Rs;
    logic [4:0]  Rt;
    logic [4:0]  Rd;
    logic [31:0] PCplus4;
    logic        Flush;

    logic        EX_Valid;
    logic        EX_ALUSrc;
    logic        EX_MemtoReg;
    logic        EX_RegWrite;
    logic        EX_MemRead;
    logic        EX_MemWrite;
    logic        EX_Branch;
    logic        EX_Jump;
    logic [1:0]  EX_ALUOp;
    logic [31:0] EX_ReadData1;
    logic [31:0] EX_ReadData2;
    logic [31:0] EX_Imm32;
    logic [31:0] EX_PCplus4;
    logic [4:0]  EX_Rs;
    logic [4:0]  EX_Rt;
    logic [4:0]  EX_WriteReg;
    logic        Stall;
    logic [15:0] BubbleCount;

    modport master (
        output ID_Valid, RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
               Branch, Jump, SignZero, ALUOp, ReadData1, ReadData2, Imm16,
               Rs, Rt, Rd, PCplus4, Flush,
        input  EX_Valid, EX_ALUSrc, EX_MemtoReg, EX_RegWrite, EX_MemRead,
               EX_MemWrite, EX_Branch, EX_Jump, EX_ALUOp, EX_ReadData1,
               EX_ReadData2, EX_Imm32, EX_PCplus4, EX_Rs, EX_Rt, EX_WriteReg,
               Stall, BubbleCount
    );

    modport slave (
        input  ID_Valid, RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
               Branch, Jump, SignZero, ALUOp, ReadData1, ReadData2, Imm16,
               Rs, Rt, Rd, PCplus4, Flush,
        output EX_Valid, EX_ALUSrc, EX_MemtoReg, EX_RegWrite, EX_MemRead,
               EX_MemWrite, EX_Branch, EX_Jump, EX_ALUOp, EX_ReadData1,
               EX_ReadData2, EX_Imm32, EX_PCplus4, EX_Rs, EX_Rt, EX_WriteReg,
               Stall, BubbleCount
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/bubble insertion
// and a saturating count of inserted bubbles.
module id_ex_stage (
    input  logic         clk,
    input  logic         reset,
    id_ex_stage_if.slave bus
);

    typedef struct packed {
        logic        valid;
        logic        alu_src;
        logic        memto_reg;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic [1:0]  alu_op;
        logic [31:0] read_data1;
        logic [31:0] read_data2;
        logic [31:0] imm32;
        logic [31:0] pc_plus4;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  write_reg;
    } ex_slot_t;

    ex_slot_t    ex_q;
    ex_slot_t    ex_d;
    ex_slot_t    load_slot;
    logic [15:0] bubble_count_q;
    logic [15:0] bubble_count_d;
    logic        stall;
    logic        reg_match;

    // Hazard only looks at the registered EX slot and this cycle's decode fields.
    always_comb begin
        reg_match = (ex_q.write_reg == bus.Rs) || (ex_q.write_reg == bus.Rt);
        stall     = ex_q.valid & ex_q.mem_read & (ex_q.write_reg != 5'd0) &
                    bus.ID_Valid & ~bus.Flush & reg_match;
    end

    always_comb begin
        load_slot            = '0;
        load_slot.valid      = bus.ID_Valid;
        load_slot.alu_src    = bus.ID_Valid & bus.ALUSrc;
        load_slot.memto_reg  = bus.ID_Valid & bus.MemtoReg;
        load_slot.reg_write  = bus.ID_Valid & bus.RegWrite;
        load_slot.mem_read   = bus.ID_Valid & bus.MemRead;
        load_slot.mem_write  = bus.ID_Valid & bus.MemWrite;
        load_slot.branch     = bus.ID_Valid & bus.Branch;
        load_slot.jump       = bus.ID_Valid & bus.Jump;
        load_slot.alu_op     = bus.ID_Valid ? bus.ALUOp : 2'b00;
        load_slot.read_data1 = bus.ReadData1;
        load_slot.read_data2 = bus.ReadData2;
        load_slot.imm32      = bus.SignZero ? {16'h0000, bus.Imm16}
                                            : {{16{bus.Imm16[15]}}, bus.Imm16};
        load_slot.pc_plus4   = bus.PCplus4;
        load_slot.rs         = bus.Rs;
        load_slot.rt         = bus.Rt;
        // Gating on RegWrite first keeps an undriven RegDst on stores out of the slot.
        load_slot.write_reg  = (bus.ID_Valid & bus.RegWrite)
                               ? (bus.RegDst ? bus.Rd : bus.Rt) : 5'd0;
    end

    always_comb begin
        ex_d = load_slot;
        if (bus.Flush || stall) begin
            ex_d = '0;
        end
        bubble_count_d = bubble_count_q;
        if (stall && (bubble_count_q != 16'hFFFF)) begin
            bubble_count_d = bubble_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q           <= '0;
            bubble_count_q <= 16'h0000;
        end else begin
            ex_q           <= ex_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign bus.EX_Valid     = ex_q.valid;
    assign bus.EX_ALUSrc    = ex_q.alu_src;
    assign bus.EX_MemtoReg  = ex_q.memto_reg;
    assign bus.EX_RegWrite  = ex_q.reg_write;
    assign bus.EX_MemRead   = ex_q.mem_read;
    assign bus.EX_MemWrite  = ex_q.mem_write;
    assign bus.EX_Branch    = ex_q.branch;
    assign bus.EX_Jump      = ex_q.jump;
    assign bus.EX_ALUOp     = ex_q.alu_op;
    assign bus.EX_ReadData1 = ex_q.read_data1;
    assign bus.EX_ReadData2 = ex_q.read_data2;
    assign bus.EX_Imm32     = ex_q.imm32;
    assign bus.EX_PCplus4   = ex_q.pc_plus4;
    assign bus.EX_Rs        = ex_q.rs;
    assign bus.EX_Rt        = ex_q.rt;
    assign bus.EX_WriteReg  = ex_q.write_reg;
    assign bus.Stall        = stall;
    assign bus.BubbleCount  = bubble_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: load, extension, load-use bubble, flush priority,
// store/zero-register, invalid slot, counter saturation and asynchronous reset.
module tb_id_ex_stage;

    logic clk;
    logic reset;
    int   checkCount;
    int   errorCount;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // ALUSrc/MemtoReg follow the memory flags; data words are derived from the register numbers.
    task automatic applyStimulus(input logic valid, input logic regDst,
                                 input logic regWrite, input logic memRead,
                                 input logic memWrite, input logic signZero,
                                 input logic [1:0] aluOp, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic [4:0] rd,
                                 input logic [15:0] imm, input logic [31:0] pc4);
        bus.ID_Valid  = valid;
        bus.RegDst    = regDst;
        bus.RegWrite  = regWrite;
        bus.MemRead   = memRead;
        bus.MemWrite  = memWrite;
        bus.MemtoReg  = memRead;
        bus.ALUSrc    = memRead | memWrite;
        bus.Branch    = 1'b0;
        bus.Jump      = 1'b0;
        bus.SignZero  = signZero;
        bus.ALUOp     = aluOp;
        bus.Rs        = rs;
        bus.Rt        = rt;
        bus.Rd        = rd;
        bus.Imm16     = imm;
        bus.PCplus4   = pc4;
        bus.ReadData1 = 32'h0000_1000 + {27'd0, rs};
        bus.ReadData2 = 32'h0000_2000 + {27'd0, rt};
        bus.Flush     = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        reset      = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 16'h0, 32'h0);

        // Reset takes effect before any clock edge.
        #1 reset = 1'b1;
        #1;
        checkOutput("rst_valid", {31'd0, bus.EX_Valid}, 32'd0);
        checkOutput("rst_wreg", {27'd0, bus.EX_WriteReg}, 32'd0);
        checkOutput("rst_bcount", {16'd0, bus.BubbleCount}, 32'd0);
        checkOutput("rst_stall", {31'd0, bus.Stall}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // R-type, sign-extended immediate
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 5'd1, 5'd2, 5'd3, 16'h8001, 32'h100);
        #1 checkOutput("rtype_stall", {31'd0, bus.Stall}, 32'd0);
        tick();
        checkOutput("rtype_valid", {31'd0, bus.EX_Valid}, 32'd1);
        checkOutput("rtype_wreg", {27'd0, bus.EX_WriteReg}, 32'd3);
        checkOutput("rtype_aluop", {30'd0, bus.EX_ALUOp}, 32'd2);
        checkOutput("rtype_regwrite", {31'd0, bus.EX_RegWrite}, 32'd1);
        checkOutput("sext_imm", bus.EX_Imm32, 32'hFFFF_8001);
        checkOutput("rtype_rd1", bus.EX_ReadData1, 32'h0000_1001);
        checkOutput("rtype_rd2", bus.EX_ReadData2, 32'h0000_2002);
        checkOutput("rtype_pc4", bus.EX_PCplus4, 32'h100);
        checkOutput("rtype_rs", {27'd0, bus.EX_Rs}, 32'd1);
        checkOutput("rtype_rt", {27'd0, bus.EX_Rt}, 32'd2);
        checkOutput("rtype_stall_after", {31'd0, bus.Stall}, 32'd0);

        // Zero-extended immediate
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 5'd1, 5'd2, 5'd3, 16'h8001, 32'h104);
        tick();
        checkOutput("zext_imm", bus.EX_Imm32, 32'h0000_8001);

        // lw r5 followed by a use of r5 in Rs: one bubble, then the held instruction loads
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 5'd1, 5'd5, 5'd9, 16'h0004, 32'h108);
        tick();
        checkOutput("lw_wreg", {27'd0, bus.EX_WriteReg}, 32'd5);
        checkOutput("lw_memread", {31'd0, bus.EX_MemRead}, 32'd1);
        checkOutput("lw_memtoreg", {31'd0, bus.EX_MemtoReg}, 32'd1);
        checkOutput("lw_alusrc", {31'd0, bus.EX_ALUSrc}, 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 5'd5, 5'd6, 5'd7, 16'h0000, 32'h10C);
        #1 checkOutput("lu_stall", {31'd0, bus.Stall}, 32'd1);
        tick();
        checkOutput("bubble_valid", {31'd0, bus.EX_Valid}, 32'd0);
        checkOutput("bubble_wreg", {27'd0, bus.EX_WriteReg}, 32'd0);
        checkOutput("bubble_aluop", {30'd0, bus.EX_ALUOp}, 32'd0);
        checkOutput("bubble_rd1", bus.EX_ReadData1, 32'd0);
        checkOutput("bubble_pc4", bus.EX_PCplus4, 32'd0);
        checkOutput("bubble_count1", {16'd0, bus.BubbleCount}, 32'd1);
        checkOutput("bubble_stall_drop", {31'd0, bus.Stall}, 32'd0);
        tick();
        checkOutput("dep_valid", {31'd0, bus.EX_Valid}, 32'd1);
        checkOutput("dep_wreg", {27'd0, bus.EX_WriteReg}, 32'd7);
        checkOutput("dep_count", {16'd0, bus.BubbleCount}, 32'd1);

        // Flush beats the would-be stall and is not counted
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 5'd1, 5'd5, 5'd9, 16'h0004, 32'h110);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 5'd5, 5'd6, 5'd7, 16'h0000, 32'h114);
        bus.Flush = 1'b1;
        #1 checkOutput("flush_stall", {31'd0, bus.Stall}, 32'd0);
        tick();
        checkOutput("flush_valid", {31'd0, bus.EX_Valid}, 32'd0);
        checkOutput("flush_pc4", bus.EX_PCplus4, 32'd0);
        checkOutput("flush_count", {16'd0, bus.BubbleCount}, 32'd1);
        bus.Flush = 1'b0;

        // Dependency through Rt
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 5'd1, 5'd5, 5'd9, 16'h0004, 32'h118);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 5'd3, 5'd5, 5'd7, 16'h0000, 32'h11C);
        #1 checkOutput("rt_stall", {31'd0, bus.Stall}, 32'd1);
        tick();
        checkOutput("rt_count", {16'd0, bus.BubbleCount}, 32'd2);

        // Store with unknown RegDst writes no register
        applyStimulus(1'b1, 1'bx, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 5'd4, 5'd8, 5'd12, 16'h0008, 32'h120);
        tick();
        checkOutput("sw_wreg", {27'd0, bus.EX_WriteReg}, 32'd0);
        checkOutput("sw_memwrite", {31'd0, bus.EX_MemWrite}, 32'd1);

        // lw to r0 never stalls a use of r0
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 5'd1, 5'd0, 5'd9, 16'h0004, 32'h124);
        tick();
        checkOutput("lw0_memread", {31'd0, bus.EX_MemRead}, 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 5'd0, 5'd0, 5'd7, 16'h0000, 32'h128);
        #1 checkOutput("r0_stall", {31'd0, bus.Stall}, 32'd0);
        tick();
        checkOutput("r0_valid", {31'd0, bus.EX_Valid}, 32'd1);
        checkOutput("r0_count", {16'd0, bus.BubbleCount}, 32'd2);

        // Invalid slot registers every control as 0
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 5'd1, 5'd2, 5'd3, 16'h0000, 32'h12C);
        bus.Branch = 1'b1;
        bus.Jump   = 1'b1;
        tick();
        checkOutput("inv_valid", {31'd0, bus.EX_Valid}, 32'd0);
        checkOutput("inv_regwrite", {31'd0, bus.EX_RegWrite}, 32'd0);
        checkOutput("inv_memread", {31'd0, bus.EX_MemRead}, 32'd0);
        checkOutput("inv_memwrite", {31'd0, bus.EX_MemWrite}, 32'd0);
        checkOutput("inv_branch", {31'd0, bus.EX_Branch}, 32'd0);
        checkOutput("inv_jump", {31'd0, bus.EX_Jump}, 32'd0);
        checkOutput("inv_aluop", {30'd0, bus.EX_ALUOp}, 32'd0);
        checkOutput("inv_wreg", {27'd0, bus.EX_WriteReg}, 32'd0);

        // Preload the counter near the top, then bubble past it
        force dut.bubble_count_q = 16'hFFFE;
        #1 release dut.bubble_count_q;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 5'd1, 5'd5, 5'd9, 16'h0004, 32'h130);
            tick();
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 5'd5, 5'd6, 5'd7, 16'h0000, 32'h134);
            #1 checkOutput("sat_stall", {31'd0, bus.Stall}, 32'd1);
            tick();
            checkOutput("sat_count", {16'd0, bus.BubbleCount}, 32'h0000_FFFF);
        end

        // Reset between edges with a hazard pending
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 5'd1, 5'd5, 5'd9, 16'h0004, 32'h138);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 5'd5, 5'd6, 5'd7, 16'h0000, 32'h13C);
        #1 checkOutput("pre_rst_stall", {31'd0, bus.Stall}, 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_valid", {31'd0, bus.EX_Valid}, 32'd0);
        checkOutput("mid_rst_memread", {31'd0, bus.EX_MemRead}, 32'd0);
        checkOutput("mid_rst_wreg", {27'd0, bus.EX_WriteReg}, 32'd0);
        checkOutput("mid_rst_rd1", bus.EX_ReadData1, 32'd0);
        checkOutput("mid_rst_count", {16'd0, bus.BubbleCount}, 32'd0);
        checkOutput("mid_rst_stall", {31'd0, bus.Stall}, 32'd0);
        #1 reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 5'd1, 5'd2, 5'd3, 16'h0001, 32'h140);
        tick();
        checkOutput("post_rst_valid", {31'd0, bus.EX_Valid}, 32'd1);
        checkOutput("post_rst_wreg", {27'd0, bus.EX_WriteReg}, 32'd3);
        checkOutput("post_rst_pc4", bus.EX_PCplus4, 32'h140);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock; reset  input  1  asynchronous active-high reset.
REQ-002 Decode-side inputs SHALL be: ID_Valid 1 (slot holds a real instruction); RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, SignZero 1 each; ALUOp 2; ReadData1, ReadData2 32; Imm16 16; Rs, Rt, Rd 5; PCplus4 32.
REQ-003 Flush  input  1: kill the instruction currently in decode (branch taken or jump resolved).
REQ-004 Registered outputs SHALL be: EX_Valid 1; EX_ALUSrc, EX_MemtoReg, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_Branch, EX_Jump 1 each; EX_ALUOp 2; EX_ReadData1, EX_ReadData2, EX_Imm32, EX_PCplus4 32; EX_Rs, EX_Rt, EX_WriteReg 5.
REQ-005 Stall  output  1 (combinational): freeze PC and IF/ID register this cycle.
REQ-006 BubbleCount  output  16: saturating count of bubbles inserted.

Function
REQ-007 Each rising clk edge SHALL perform exactly one action, priority order: Flush > Bubble (Stall=1) > Load.
REQ-008 Load: all EX_ outputs SHALL take the corresponding decode-side values; EX_Valid SHALL take ID_Valid.
REQ-009 EX_Imm32 SHALL be {16'h0000, Imm16} when SignZero=1 and {16{Imm16[15]}, Imm16} when SignZero=0.
REQ-010 EX_WriteReg SHALL be Rd when RegDst=1, Rt when RegDst=0, and 5'd0 whenever RegWrite=0 or ID_Valid=0 (no unknown RegDst propagates).
REQ-011 Any decode control input with ID_Valid=0 SHALL be registered as 0.
REQ-012 Stall SHALL be 1 iff EX_Valid & EX_MemRead & (EX_WriteReg != 0) & ID_Valid & ~Flush & (EX_WriteReg == Rs | EX_WriteReg == Rt).
REQ-013 Bubble and Flush SHALL set EX_Valid and all EX_ control outputs (including EX_ALUOp=2'b00) and EX_WriteReg to 0; data fields (EX_ReadData1/2, EX_Imm32, EX_PCplus4, EX_Rs, EX_Rt) SHALL also be cleared to 0.
REQ-014 BubbleCount SHALL increment by 1 on every Bubble edge and hold at 16'hFFFF once reached; Flush edges SHALL NOT count.
REQ-015 A load-use dependency SHALL cost exactly one bubble: the edge after a Bubble the EX slot is empty, so Stall drops and the held decode instruction is loaded.
REQ-016 Flush and a would-be Stall in the same cycle SHALL produce Stall=0 and a Flush action.
REQ-017 Register 0 SHALL never cause a stall, regardless of Rs/Rt.
REQ-018 Stall SHALL depend only on current-cycle inputs and registered state (no combinational loop through upstream).

Reset
REQ-019 While reset=1, all registered outputs SHALL be 0 and BubbleCount SHALL be 16'h0000, asynchronously and independent of clk.
REQ-020 Reset asserted mid-operation SHALL discard the held instruction; the first edge after release SHALL be a normal Load.
REQ-021 Stall SHALL be 0 during reset, because EX_Valid=0.

Verification
REQ-022 R-type load: ID_Valid=1, RegDst=1, RegWrite=1, ALUOp=10, Rs=1, Rt=2, Rd=3 -> next edge EX_WriteReg=3, EX_ALUOp=10, EX_Valid=1, Stall=0.
REQ-023 Extension: Imm16=16'h8001, SignZero=0 -> EX_Imm32=32'hFFFF8001; SignZero=1 -> 32'h00008001.
REQ-024 Load-use: lw with Rt=5 loaded, then decode instruction with Rs=5 -> Stall=1 for one cycle; next EX_Valid=0, BubbleCount=1; the following edge loads the dependent instruction.
REQ-025 Flush priority: same lw/Rs=5 setup with Flush=1 -> Stall=0, EX_Valid=0 after the edge, BubbleCount unchanged.
REQ-026 Store/zero-register: sw (RegWrite=0, RegDst=x) -> EX_WriteReg=0; lw writing reg 0 followed by a use of Rs=0 -> Stall=0.
REQ-027 Saturation/reset: force 65536 bubbles -> BubbleCount=16'hFFFF held; assert reset between edges -> all outputs 0 immediately.
